// File: rtl/tt_pin_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : tt_pin_mem_bridge_if
// Description : 32-bit core memory port (request/response) for the pin bridge.
// Revision    : 1.0  initial release
// ============================================================================
interface tt_pin_mem_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/tt_pin_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tt_pin_mem_bridge
// Description : Serialises core loads/stores into byte frames on the TT pins.
// Revision    : 1.0  initial release
// ============================================================================
module tt_pin_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TCNT_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tt_pin_mem_bridge_if.slave       mem,
    output logic [7:0]               pin_out,
    output logic [7:0]               pin_oe,
    input  logic [7:0]               pin_in,
    output logic                     pin_frame,
    output logic                     pin_strobe,
    input  logic                     pin_rvalid,
    input  logic                     pin_ack
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_TURN, ST_RDATA, ST_WAIT_ACK, ST_RESP
    } state_t;

    localparam logic [TCNT_W-1:0] TLIMIT = TCNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [7:0]          pin_out_q, pin_out_d;
    logic [7:0]          pin_oe_q, pin_oe_d;
    logic                pin_frame_q, pin_frame_d;
    logic                pin_strobe_q, pin_strobe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            pin_out_q    <= '0;
            pin_oe_q     <= '0;
            pin_frame_q  <= 1'b0;
            pin_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            pin_out_q    <= pin_out_d;
            pin_oe_q     <= pin_oe_d;
            pin_frame_q  <= pin_frame_d;
            pin_strobe_q <= pin_strobe_d;
        end
    end

    // Next state; a pin event always beats the timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (mem.req_valid) begin
                    state_d = ST_CMD;
                    we_d    = mem.req_we;
                    addr_d  = mem.req_addr;
                    wdata_d = mem.req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_CMD: begin
                state_d = ST_ADDR;
                cnt_d   = 2'd0;
            end
            ST_ADDR: begin
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    tcnt_d  = '0;
                    state_d = we_q ? ST_WDATA : ST_TURN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_WDATA: begin
                if (cnt_q == 2'd3) begin
                    state_d = ST_WAIT_ACK;
                    tcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_TURN: begin
                state_d = ST_RDATA;
                cnt_d   = 2'd0;
                tcnt_d  = '0;
            end
            ST_RDATA: begin
                if (pin_rvalid) begin
                    case (cnt_q)
                        2'd0:    rdata_d[7:0]   = pin_in;
                        2'd1:    rdata_d[15:8]  = pin_in;
                        2'd2:    rdata_d[23:16] = pin_in;
                        default: rdata_d[31:24] = pin_in;
                    endcase
                    tcnt_d = '0;
                    if (cnt_q == 2'd3) state_d = ST_RESP;
                    else               cnt_d   = cnt_q + 2'd1;
                end else if (tcnt_q == TLIMIT) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (pin_ack) begin
                    state_d = ST_RESP;
                end else if (tcnt_q == TLIMIT) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        req_ready_d  = (state_d == ST_IDLE);
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
        pin_out_d    = '0;
        pin_frame_d  = 1'b0;
        pin_strobe_d = 1'b0;
        case (state_d)
            ST_CMD: begin
                pin_out_d    = we_d ? 8'h02 : 8'h01;
                pin_strobe_d = 1'b1;
                pin_frame_d  = 1'b1;
            end
            ST_ADDR: begin
                case (cnt_d)
                    2'd0:    pin_out_d = addr_d[31:24];
                    2'd1:    pin_out_d = addr_d[23:16];
                    2'd2:    pin_out_d = addr_d[15:8];
                    default: pin_out_d = addr_d[7:0];
                endcase
                pin_strobe_d = 1'b1;
                pin_frame_d  = 1'b1;
            end
            ST_WDATA: begin
                case (cnt_d)
                    2'd0:    pin_out_d = wdata_d[7:0];
                    2'd1:    pin_out_d = wdata_d[15:8];
                    2'd2:    pin_out_d = wdata_d[23:16];
                    default: pin_out_d = wdata_d[31:24];
                endcase
                pin_strobe_d = 1'b1;
                pin_frame_d  = 1'b1;
            end
            ST_TURN, ST_RDATA, ST_WAIT_ACK: pin_frame_d = 1'b1;
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_d;
                rsp_rdata_d = (!we_d && !err_d) ? rdata_d : 32'h0;
            end
            default: ;
        endcase
        pin_oe_d = pin_strobe_d ? 8'hFF : 8'h00;
    end

    assign mem.req_ready = req_ready_q;
    assign mem.rsp_valid = rsp_valid_q;
    assign mem.rsp_rdata = rsp_rdata_q;
    assign mem.rsp_err   = rsp_err_q;
    assign pin_out       = pin_out_q;
    assign pin_oe        = pin_oe_q;
    assign pin_frame     = pin_frame_q;
    assign pin_strobe    = pin_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_pin_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_pin_mem_bridge
// Description : Directed bench for tt_pin_mem_bridge with response scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tt_pin_mem_bridge;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pin_out, pin_oe, pin_in;
    logic       pin_frame, pin_strobe, pin_rvalid, pin_ack;

    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t mon_e;

    tt_pin_mem_bridge_if bus ();

    tt_pin_mem_bridge #(
        .TIMEOUT_CYCLES (TO),
        .TCNT_W         (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus),
        .pin_out    (pin_out),
        .pin_oe     (pin_oe),
        .pin_in     (pin_in),
        .pin_frame  (pin_frame),
        .pin_strobe (pin_strobe),
        .pin_rvalid (pin_rvalid),
        .pin_ack    (pin_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err, pin_frame, pin_strobe,
                    pin_oe, pin_out, bus.rsp_rdata});
    endfunction

    // Idle/reset image of all_outs(): only req_ready high.
    localparam logic [63:0] IDLE_OUTS = 64'(53'h1 << 52);

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid === 1'b1) begin
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
                chk("rsp_err",   64'(bus.rsp_err),   64'(mon_e.err));
                chk("rsp_cycle", 64'(cyc),           64'(mon_e.cyc));
            end
        end
    end

    // One transaction from its accept cycle (cycle 0) through RESP; ev bit c
    // marks a device event (ack or read byte) in cycle c after accept.
    task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rword,
                          input logic [31:0] ev, input logic junk, input logic hold);
        int          start, nb, run, rc, bi;
        logic        err, es, ef, er;
        logic [7:0]  eo;
        logic [31:0] sh;
        exp_t        e;
        start = we ? 10 : 7;
        nb = 0; run = 0; rc = 0; err = 1'b0;
        for (int c = start; c < 32 && rc == 0; c++) begin
            if (ev[c]) begin
                if (we) rc = c + 1;
                else begin
                    nb++; run = 0;
                    if (nb == 4) rc = c + 1;
                end
            end else begin
                run++;
                if (run == TO) begin rc = c + 1; err = 1'b1; end
            end
        end
        e.rdata = (!we && !err) ? rword : 32'h0;
        e.err   = err;
        e.cyc   = cyc + rc;
        chk($sformatf("%s_c0", name), all_outs(), IDLE_OUTS);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        sb.push_back(e);
        bi = 0;
        for (int c = 1; c <= rc; c++) begin
            @(posedge clk); #1;
            if (c == 1 && !hold) bus.req_valid = 1'b0;
            pin_rvalid = 1'b0; pin_ack = 1'b0; pin_in = 8'h5A;
            if (junk && c <= 5) begin pin_rvalid = 1'b1; pin_ack = 1'b1; pin_in = 8'hA5; end
            if (ev[c]) begin
                if (we) pin_ack = 1'b1;
                else begin
                    pin_rvalid = 1'b1;
                    sh = rword >> (8 * bi);
                    pin_in = sh[7:0];
                    bi++;
                end
            end
            eo = 8'h00; es = 1'b0; ef = 1'b0; er = 1'b0;
            if (c == 1) begin
                eo = we ? 8'h02 : 8'h01; es = 1'b1; ef = 1'b1;
            end else if (c <= 5) begin
                sh = addr >> (8 * (5 - c)); eo = sh[7:0]; es = 1'b1; ef = 1'b1;
            end else if (we && c <= 9) begin
                sh = wdata >> (8 * (c - 6)); eo = sh[7:0]; es = 1'b1; ef = 1'b1;
            end else if (c < rc) begin
                ef = 1'b1;
            end else begin
                er = 1'b1;
            end
            chk($sformatf("%s_c%0d", name, c),
                64'({bus.req_ready, bus.rsp_valid, pin_frame, pin_strobe, pin_oe, pin_out}),
                64'({1'b0, er, ef, es, es ? 8'hFF : 8'h00, eo}));
        end
        @(posedge clk); #1;
        pin_rvalid = 1'b0; pin_ack = 1'b0; pin_in = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        pin_in = 8'h00; pin_rvalid = 1'b0; pin_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outs", all_outs(), IDLE_OUTS);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_outs", all_outs(), IDLE_OUTS);

        do_txn("wr_basic", 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0, 32'h1 << 10, 1'b0, 1'b0);
        do_txn("rd_basic", 1'b0, 32'h8000_0004, 32'h0, 32'h1234_5678,
               (32'h1 << 7) | (32'h1 << 8) | (32'h1 << 9) | (32'h1 << 10), 1'b0, 1'b0);
        do_txn("rd_gaps", 1'b0, 32'h0102_0304, 32'h0, 32'hCAFE_F00D,
               (32'h1 << 7) | (32'h1 << 9) | (32'h1 << 10) | (32'h1 << 13), 1'b1, 1'b0);
        do_txn("wr_timeout", 1'b1, 32'h0000_00F0, 32'h1111_2222, 32'h0, 32'h0, 1'b1, 1'b0);
        do_txn("wr_ack_at_limit", 1'b1, 32'h0000_00F4, 32'h3333_4444, 32'h0,
               32'h1 << 13, 1'b0, 1'b0);
        do_txn("rd_timeout", 1'b0, 32'h0000_0100, 32'h0, 32'hAABB_CCDD,
               (32'h1 << 7) | (32'h1 << 8), 1'b0, 1'b0);

        // Abort a read in ADDR; no response may follow.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h00AB_CDEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_in_addr_strobe", 64'({pin_strobe, pin_oe}), 64'({1'b1, 8'hFF}));
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", all_outs(), IDLE_OUTS);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn("rd_after_reset", 1'b0, 32'h00AB_CDEF, 32'h0, 32'h8765_4321,
               (32'h1 << 7) | (32'h1 << 8) | (32'h1 << 9) | (32'h1 << 10), 1'b0, 1'b0);

        do_txn("b2b_wr", 1'b1, 32'h0000_0200, 32'h5566_7788, 32'h0, 32'h1 << 10, 1'b0, 1'b1);
        do_txn("b2b_rd", 1'b0, 32'h0000_0204, 32'h0, 32'h0BAD_CAFE,
               (32'h1 << 7) | (32'h1 << 8) | (32'h1 << 9) | (32'h1 << 10), 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1 chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_pin_mem_bridge.md
Name: tt_pin_mem_bridge

Overview:
- Sits between the RISC-V core's 32-bit memory port and the Tiny Tapeout top-level pins.
- Serialises each core load/store into a byte-wide framed transaction on the bidirectional uio bus; control strobes go out on uo_out.
- Collects read data bytes and completion acks arriving on ui_in/uio_in, then returns a single-cycle response to the core.
- Handles one outstanding request at a time; no buffering beyond the captured request.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent waiting in RDATA or WAIT_ACK without pin activity before an error response is issued. Legal range 1..255.
- TCNT_W, 8: width of the timeout counter; must satisfy 2**TCNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  bridge can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  one-cycle response pulse; no back-pressure.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  timeout error, qualified by rsp_valid.
- pin_out  out  8  byte driven toward uio_out.
- pin_oe  out  8  toward uio_oe; 8'hFF while driving, 8'h00 otherwise.
- pin_in  in  8  from uio_in.
- pin_frame  out  1  high from CMD through the last wait cycle.
- pin_strobe  out  1  high in each cycle pin_out carries a valid outbound byte.
- pin_rvalid  in  1  external device presents a read byte on pin_in this cycle.
- pin_ack  in  1  external device confirms a store.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, pin_out=0, pin_oe=0, pin_frame=0, pin_strobe=0. The FSM returns to IDLE.
- Reset asserted mid-transaction aborts it immediately with no response. After reset the bridge is in IDLE.
- Accept: in IDLE, when req_valid && req_ready, capture addr/wdata/we. The next cycle enters CMD.
- States and transitions:
  - IDLE: waits for an accepted request.
  - CMD (1 cycle): pin_out = 8'h01 for a read or 8'h02 for a write; strobe=1, oe=FF, frame=1.
  - ADDR (4 cycles): address bytes MSB first (addr[31:24] .. addr[7:0]); strobe=1, oe=FF.
  - Write path: ADDR -> WDATA (4 cycles, LSB first: wdata[7:0] .. wdata[31:24]; strobe=1) -> WAIT_ACK.
  - Read path: ADDR -> TURN (1 cycle; oe=00, strobe=0, pin_out=0, frame=1) -> RDATA.
- RDATA:
  - oe=00.
  - Each cycle with pin_rvalid=1 stores pin_in into the next byte slot, LSB first.
  - After the 4th byte, go to RESP.
- WAIT_ACK:
  - oe=00.
  - pin_ack=1 goes to RESP; the ack is sampled in the same cycle, so the minimum stay is 1 cycle.
- Timeout counter:
  - Cleared on entry to RDATA/WAIT_ACK and on every accepted read byte.
  - Increments in each RDATA/WAIT_ACK cycle that has no pin event.
  - When it reaches TIMEOUT_CYCLES without an event, go to RESP with the error flag set.
  - A pin event in the same cycle as the limit wins: no error.
- RESP (1 cycle):
  - rsp_valid=1, frame=0, oe=00.
  - rsp_rdata = assembled word for a successful read, else 0.
  - rsp_err = 1 on timeout.
  - Next state: IDLE.
- Pin inputs outside their states are ignored: pin_rvalid outside RDATA, pin_ack outside WAIT_ACK.
- req_ready is low from CMD through RESP. A new request can be accepted the cycle after RESP.
- Latency: with accept edge as cycle 0 and zero pin stall, rsp_valid is high in cycle 11 for both reads and writes. Each stall cycle adds 1.
- pin_oe is never FF in TURN or later states. This guarantees one dead cycle before the external device drives.

Test Plan:
- Write addr=32'h0000_1234, wdata=32'hDEAD_BEEF, pin_ack on first WAIT_ACK cycle -> pin_out sequence 02,00,00,12,34,EF,BE,AD,DE with strobe=1 and oe=FF; rsp_valid in cycle 11 with rsp_err=0, rsp_rdata=0.
- Read addr=32'h8000_0004, device returns bytes 78,56,34,12 on consecutive cycles after TURN -> pin_out 01,80,00,00,04; oe=00 from TURN; rsp_rdata=32'h1234_5678 in cycle 11.
- Read with pin_rvalid gaps (bytes in RDATA cycles 1,3,4,7) -> rsp_rdata correct; rsp_valid delayed by exactly 3 cycles; no error.
- Write with pin_ack never asserted, TIMEOUT_CYCLES=4 -> rsp_valid with rsp_err=1 after 4 WAIT_ACK cycles; pin_ack/pin_rvalid pulsed during CMD/ADDR have no effect.
- rst_n pulled low during ADDR -> all outputs return to reset values asynchronously; no rsp_valid; a fresh read after release completes normally.
- req_valid held high continuously across two back-to-back requests -> second accepted the cycle after RESP; req_ready low throughout the first transaction.
